mem_mux: RTL and testbench

- Arbiter/mux in front of the RTC register file.
- Merges two access sources onto one register-file port:
  - timekeeping core write port: addr, data_out, write_en
  - I2C slave read port: i2c_addr, i2c_read_en
- Drives the register file's address, write data and write enable from registered outputs.
- The register file returns read data combinationally at reg_addr; that path is outside this block.

---
 rtl/mem_mux_if.sv | 31 +++
 rtl/mem_mux.sv | 62 ++++++
 tb/tb_mem_mux.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_mux_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_mux_if
// Brief    : Request and register-file bus bundle for the RTC register mux.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_mux_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_out;
    logic              write_en;
    logic [ADDR_W-1:0] i2c_addr;
    logic              i2c_read_en;
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] data_in;
    logic              reg_write_en;

    // The master issues requests and observes the register-file side.
    modport master (
        output addr, data_out, write_en, i2c_addr, i2c_read_en,
        input  reg_addr, data_in, reg_write_en
    );

    modport slave (
        input  addr, data_out, write_en, i2c_addr, i2c_read_en,
        output reg_addr, data_in, reg_write_en
    );
endinterface : mem_mux_if
`default_nettype wire

// File: rtl/mem_mux.sv
`default_nettype none
// ============================================================================
// Module   : mem_mux
// Brief    : Core-write / I2C-read arbiter in front of the RTC register file.
// Revision : 1.0 - initial release
// ============================================================================
module mem_mux #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  wire logic clk,
    input  wire logic rst,
    mem_mux_if.slave  bus
);

    localparam logic [ADDR_W-1:0] c_addr_zero = '0;
    localparam logic [DATA_W-1:0] c_data_zero = '0;

    logic [ADDR_W-1:0] r_reg_addr;
    logic [DATA_W-1:0] r_data_in;
    logic              r_reg_write_en;
    logic              r_pending;
    logic [ADDR_W-1:0] r_pending_addr;

    // Writes always win; a read that collides with a write, or arrives while
    // an earlier read is being replayed, waits one slot (newest read wins).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg_addr     <= c_addr_zero;
            r_data_in      <= c_data_zero;
            r_reg_write_en <= 1'b0;
            r_pending      <= 1'b0;
            r_pending_addr <= c_addr_zero;
        end else if (bus.write_en) begin
            r_reg_addr     <= bus.addr;
            r_data_in      <= bus.data_out;
            r_reg_write_en <= 1'b1;
            if (bus.i2c_read_en) begin
                r_pending      <= 1'b1;
                r_pending_addr <= bus.i2c_addr;
            end
        end else if (r_pending) begin
            r_reg_addr     <= r_pending_addr;
            r_reg_write_en <= 1'b0;
            r_pending      <= bus.i2c_read_en;
            if (bus.i2c_read_en) begin
                r_pending_addr <= bus.i2c_addr;
            end
        end else if (bus.i2c_read_en) begin
            r_reg_addr     <= bus.i2c_addr;
            r_reg_write_en <= 1'b0;
        end else begin
            r_reg_write_en <= 1'b0;
        end
    end

    assign bus.reg_addr     = r_reg_addr;
    assign bus.data_in      = r_data_in;
    assign bus.reg_write_en = r_reg_write_en;

endmodule : mem_mux
`default_nettype wire

// File: tb/tb_mem_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_mux
// Brief    : Directed self-checking bench for mem_mux.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_mux;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    mem_mux_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.write_en    = 1'b0;
        bus.i2c_read_en = 1'b0;
        bus.addr        = '0;
        bus.data_out    = '0;
        bus.i2c_addr    = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.write_en = 1'b1; bus.addr = 4'd5; bus.data_out = 8'hAA;
        bus.i2c_read_en = 1'b1; bus.i2c_addr = 4'd3;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (bus.reg_addr !== 4'd0 || bus.data_in !== 8'd0 || bus.reg_write_en !== 1'b0) begin
                errors++;
                $display("FAIL reset cyc%0d: got addr=%0d data=%0h we=%b, need 0/0/0",
                         i, bus.reg_addr, bus.data_in, bus.reg_write_en);
            end
        end
        rst = 1'b0;
        idle_inputs();
        tick();
        checks++;
        if (bus.reg_addr !== 4'd0 || bus.reg_write_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_drop: got addr=%0d we=%b, need 0/0", bus.reg_addr, bus.reg_write_en);
        end
    endtask

    task automatic test_single_write();
        bus.write_en = 1'b1; bus.addr = 4'd0; bus.data_out = 8'd10;
        tick();
        checks++;
        if (bus.reg_addr !== 4'd0 || bus.data_in !== 8'd10 || bus.reg_write_en !== 1'b1) begin
            errors++;
            $display("FAIL write0: got addr=%0d data=%0d we=%b, need 0/10/1",
                     bus.reg_addr, bus.data_in, bus.reg_write_en);
        end
        idle_inputs();
        tick();
        checks++;
        if (bus.data_in !== 8'd10 || bus.reg_write_en !== 1'b0) begin
            errors++;
            $display("FAIL write0_after: got data=%0d we=%b, need 10/0", bus.data_in, bus.reg_write_en);
        end
        bus.write_en = 1'b1; bus.addr = 4'd1; bus.data_out = 8'd15;
        tick();
        checks++;
        if (bus.reg_addr !== 4'd1 || bus.data_in !== 8'd15 || bus.reg_write_en !== 1'b1) begin
            errors++;
            $display("FAIL write1: got addr=%0d data=%0d we=%b, need 1/15/1",
                     bus.reg_addr, bus.data_in, bus.reg_write_en);
        end
        idle_inputs();
        tick();
        checks++;
        if (bus.reg_addr !== 4'd1 || bus.reg_write_en !== 1'b0) begin
            errors++;
            $display("FAIL write1_after: got addr=%0d we=%b, need 1/0", bus.reg_addr, bus.reg_write_en);
        end
    endtask

    task automatic test_i2c_read();
        bus.i2c_read_en = 1'b1; bus.i2c_addr = 4'd0; bus.addr = 4'd2; bus.data_out = 8'd0;
        tick();
        checks++;
        if (bus.reg_addr !== 4'd0 || bus.reg_write_en !== 1'b0 || bus.data_in !== 8'd15) begin
            errors++;
            $display("FAIL read0: got addr=%0d data=%0d we=%b, need 0/15/0",
                     bus.reg_addr, bus.data_in, bus.reg_write_en);
        end
        idle_inputs();
        bus.addr = 4'd9; bus.i2c_addr = 4'd12; bus.data_out = 8'h77;
        tick();
        tick();
        checks++;
        if (bus.reg_addr !== 4'd0 || bus.data_in !== 8'd15 || bus.reg_write_en !== 1'b0) begin
            errors++;
            $display("FAIL read_hold: got addr=%0d data=%0d we=%b, need 0/15/0",
                     bus.reg_addr, bus.data_in, bus.reg_write_en);
        end
        idle_inputs();
    endtask

    task automatic test_collision();
        bus.write_en = 1'b1; bus.addr = 4'd3; bus.data_out = 8'h42;
        bus.i2c_read_en = 1'b1; bus.i2c_addr = 4'd7;
        tick();
        checks++;
        if (bus.reg_addr !== 4'd3 || bus.data_in !== 8'h42 || bus.reg_write_en !== 1'b1) begin
            errors++;
            $display("FAIL coll_write: got addr=%0d data=%0h we=%b, need 3/42/1",
                     bus.reg_addr, bus.data_in, bus.reg_write_en);
        end
        idle_inputs();
        tick();
        checks++;
        if (bus.reg_addr !== 4'd7 || bus.reg_write_en !== 1'b0 || bus.data_in !== 8'h42) begin
            errors++;
            $display("FAIL coll_read: got addr=%0d data=%0h we=%b, need 7/42/0",
                     bus.reg_addr, bus.data_in, bus.reg_write_en);
        end
        tick();
        checks++;
        if (bus.reg_addr !== 4'd7) begin
            errors++;
            $display("FAIL coll_hold: got addr=%0d, need 7", bus.reg_addr);
        end
    endtask

    task automatic test_pending_plus_read();
        bus.write_en = 1'b1; bus.addr = 4'd3; bus.data_out = 8'h42;
        bus.i2c_read_en = 1'b1; bus.i2c_addr = 4'd7;
        tick();
        bus.write_en = 1'b0; bus.i2c_read_en = 1'b1; bus.i2c_addr = 4'd9;
        tick();
        checks++;
        if (bus.reg_addr !== 4'd7 || bus.reg_write_en !== 1'b0) begin
            errors++;
            $display("FAIL pend_first: got addr=%0d we=%b, need 7/0", bus.reg_addr, bus.reg_write_en);
        end
        idle_inputs();
        tick();
        checks++;
        if (bus.reg_addr !== 4'd9 || bus.reg_write_en !== 1'b0) begin
            errors++;
            $display("FAIL pend_second: got addr=%0d we=%b, need 9/0", bus.reg_addr, bus.reg_write_en);
        end
        tick();
        checks++;
        if (bus.reg_addr !== 4'd9) begin
            errors++;
            $display("FAIL pend_drained: got addr=%0d, need 9", bus.reg_addr);
        end
    endtask

    task automatic test_write_over_pending();
        // Two collisions in a row: the newer read replaces the older one.
        bus.write_en = 1'b1; bus.addr = 4'd2; bus.data_out = 8'h55;
        bus.i2c_read_en = 1'b1; bus.i2c_addr = 4'd7;
        tick();
        bus.addr = 4'd4; bus.data_out = 8'h66; bus.i2c_addr = 4'd8;
        tick();
        checks++;
        if (bus.reg_addr !== 4'd4 || bus.data_in !== 8'h66 || bus.reg_write_en !== 1'b1) begin
            errors++;
            $display("FAIL wop_write: got addr=%0d data=%0h we=%b, need 4/66/1",
                     bus.reg_addr, bus.data_in, bus.reg_write_en);
        end
        // A plain write while a read is pending keeps the read waiting.
        bus.i2c_read_en = 1'b0; bus.addr = 4'd5; bus.data_out = 8'h99;
        tick();
        checks++;
        if (bus.reg_addr !== 4'd5 || bus.data_in !== 8'h99 || bus.reg_write_en !== 1'b1) begin
            errors++;
            $display("FAIL wop_write2: got addr=%0d data=%0h we=%b, need 5/99/1",
                     bus.reg_addr, bus.data_in, bus.reg_write_en);
        end
        idle_inputs();
        tick();
        checks++;
        if (bus.reg_addr !== 4'd8 || bus.reg_write_en !== 1'b0 || bus.data_in !== 8'h99) begin
            errors++;
            $display("FAIL wop_newest: got addr=%0d data=%0h we=%b, need 8/99/0",
                     bus.reg_addr, bus.data_in, bus.reg_write_en);
        end
    endtask

    task automatic test_back_to_back();
        bus.write_en = 1'b1; bus.addr = 4'd4; bus.data_out = 8'h14;
        bus.i2c_read_en = 1'b1; bus.i2c_addr = 4'd11;
        tick();
        checks++;
        if (bus.reg_addr !== 4'd4 || bus.data_in !== 8'h14 || bus.reg_write_en !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: got addr=%0d data=%0h we=%b, need 4/14/1",
                     bus.reg_addr, bus.data_in, bus.reg_write_en);
        end
        rst = 1'b1; bus.i2c_read_en = 1'b0; bus.addr = 4'd5; bus.data_out = 8'h15;
        tick();
        checks++;
        if (bus.reg_addr !== 4'd0 || bus.data_in !== 8'd0 || bus.reg_write_en !== 1'b0) begin
            errors++;
            $display("FAIL b2b_reset: got addr=%0d data=%0h we=%b, need 0/0/0",
                     bus.reg_addr, bus.data_in, bus.reg_write_en);
        end
        rst = 1'b0; bus.addr = 4'd6; bus.data_out = 8'h16;
        tick();
        checks++;
        if (bus.reg_addr !== 4'd6 || bus.data_in !== 8'h16 || bus.reg_write_en !== 1'b1) begin
            errors++;
            $display("FAIL b2b_third: got addr=%0d data=%0h we=%b, need 6/16/1",
                     bus.reg_addr, bus.data_in, bus.reg_write_en);
        end
        idle_inputs();
        tick();
        checks++;
        if (bus.reg_addr !== 4'd6 || bus.reg_write_en !== 1'b0 || bus.data_in !== 8'h16) begin
            errors++;
            $display("FAIL b2b_no_pending: got addr=%0d data=%0h we=%b, need 6/16/0",
                     bus.reg_addr, bus.data_in, bus.reg_write_en);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        idle_inputs();
        test_reset();
        test_single_write();
        test_i2c_read();
        test_collision();
        test_pending_plus_read();
        test_write_over_pending();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mem_mux
`default_nettype wire
